// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit control blocks.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int UART_BAUD_DIV = 325;
    localparam int UART_NBITS    = 8;
    localparam int LOAD_CYCLES   = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    localparam int IW1 = IW + 1;

    logic [IW1-1:0] cand;
    logic           found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + IW1'(i);
            if (cand >= IW1'(NREQ)) begin
                cand = cand - IW1'(NREQ);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[IW-1:0];
            end
        end
        gnt[gnt_idx] = found;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NREQ requesters, round-robin, with done/timeout and idle gap.
//   state | meaning
//   IDLE  | waiting for any request; grant registered on exit
//   LOAD  | TxEn high for LOAD_CYCLES with latched byte
//   WAIT  | waiting for synchronized TxDone rise or timeout
//   GAP   | enforced idle so the transmitter returns to idle
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int GAP_CYCLES     = 400
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic [NREQ-1:0]            Req,
    input  logic [UART_NBITS*NREQ-1:0] ReqData,
    output logic [NREQ-1:0]            Ack,
    output logic                       Err,
    output logic                       Busy,
    output logic [UART_NBITS-1:0]      TxData,
    output logic                       TxEn,
    input  logic                       TxDone
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = $clog2(GAP_CYCLES);

    state_t                  state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [IW-1:0]           gidx_q, gidx_d;
    logic [NREQ-1:0]         gnt_q, gnt_d;
    logic [UART_NBITS-1:0]   data_q, data_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [GW-1:0]           gcnt_q, gcnt_d;
    logic [NREQ-1:0]         ack_q, ack_d;
    logic                    err_q, err_d;
    logic [2:0]              sync_q, sync_d;

    logic [NREQ-1:0]         arb_gnt;
    logic [IW-1:0]           arb_idx;
    logic [UART_NBITS-1:0]   arb_data;
    logic                    done_rise;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req     (Req),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        arb_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) begin
                arb_data = ReqData[UART_NBITS*i +: UART_NBITS];
            end
        end
    end

    // Two synchronizer stages followed by the edge register; a level already high is not an edge.
    assign sync_d    = {sync_q[1:0], TxDone};
    assign done_rise = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        tcnt_d  = tcnt_q + 1'b1;
        gcnt_d  = gcnt_q + 1'b1;
        ack_d   = '0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                gcnt_d = '0;
                if (|arb_gnt) begin
                    gnt_d   = arb_gnt;
                    gidx_d  = arb_idx;
                    data_d  = arb_data;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tcnt_d = '0;
                if (gcnt_q == GW'(LOAD_CYCLES - 1)) begin
                    gcnt_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                gcnt_d = '0;
                if (done_rise || (tcnt_q == TW'(TIMEOUT_CYCLES - 1))) begin
                    ack_d   = gnt_q;
                    err_d   = ~done_rise;
                    tcnt_d  = '0;
                    ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                tcnt_d = '0;
                if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
                    gcnt_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            sync_q  <= sync_d;
        end
    end

    assign TxEn   = (state_q == ST_LOAD);
    assign TxData = data_q;
    assign Busy   = (state_q != ST_IDLE);
    assign Ack    = ack_q;
    assign Err    = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple UART TX done model.
module tb_uart_tx_scheduler;

    logic        Clk;
    logic        Rst_n;
    logic [3:0]  Req;
    logic [31:0] ReqData;
    logic [3:0]  Ack;
    logic        Err;
    logic        Busy;
    logic [7:0]  TxData;
    logic        TxEn;
    logic        TxDone;

    bit model_on;
    int total;
    int bad;

    int en_first, en_count, data_at_en, data_changes;
    int ack_cyc, ack_val, ack_count, err_at_ack, err_count, busy_low;

    uart_tx_scheduler #(
        .NREQ           (4),
        .TIMEOUT_CYCLES (200),
        .GAP_CYCLES     (20)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Req     (Req),
        .ReqData (ReqData),
        .Ack     (Ack),
        .Err     (Err),
        .Busy    (Busy),
        .TxData  (TxData),
        .TxEn    (TxEn),
        .TxDone  (TxDone)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // TX model: done rises 100 cycles after TxEn rise, falls 30 cycles later.
    initial begin
        int since;
        bit prev_en;
        since   = -1;
        prev_en = 1'b0;
        TxDone  = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Rst_n) begin
                since  = -1;
                TxDone = 1'b0;
            end else if (TxEn && !prev_en) begin
                since  = 0;
                TxDone = 1'b0;
            end else if (since >= 0) begin
                since++;
                if (since == 100 && model_on) TxDone = 1'b1;
                if (since == 130) begin
                    TxDone = 1'b0;
                    since  = -1;
                end
            end
            prev_en = TxEn;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Observes one frame from the cycle after the call; cycle numbers are relative to the call.
    task automatic observe(input int budget, input bit drop_on_ack, input int drop_cyc);
        en_first     = -1;
        en_count     = 0;
        data_at_en   = -1;
        data_changes = 0;
        ack_cyc      = -1;
        ack_val      = 0;
        ack_count    = 0;
        err_at_ack   = 0;
        err_count    = 0;
        busy_low     = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge Clk);
            if (TxEn) begin
                if (en_first < 0) begin
                    en_first   = i;
                    data_at_en = int'(TxData);
                end
                en_count++;
            end
            if (en_first >= 0 && Busy && int'(TxData) != data_at_en) data_changes++;
            if (Err) err_count++;
            if (Ack != 4'b0) begin
                ack_count++;
                if (ack_cyc < 0) begin
                    ack_cyc    = i;
                    ack_val    = int'(Ack);
                    err_at_ack = int'(Err);
                end
                if (drop_on_ack) Req = Req & ~Ack;
            end
            if (i == drop_cyc) Req = 4'b0;
            if (ack_cyc >= 0 && !Busy) begin
                busy_low = i;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        model_on = 1'b1;
        Rst_n    = 1'b0;
        Req      = 4'b0;
        ReqData  = 32'h0;
        repeat (3) @(negedge Clk);
        check("rst_busy", Busy, 0);
        check("rst_txen", TxEn, 0);
        check("rst_txdata", TxData, 0);
        check("rst_ack", Ack, 0);
        check("rst_err", Err, 0);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Test 1: single request from requester 1
        ReqData = 32'h0000_5500;
        Req     = 4'b0010;
        observe(400, 1'b1, 0);
        check("t1_en_first", en_first, 1);
        check("t1_en_len", en_count, 2);
        check("t1_data", data_at_en, 32'h55);
        check("t1_hold", data_changes, 0);
        check("t1_ack_cyc", ack_cyc, 104);
        check("t1_ack_val", ack_val, 4'b0010);
        check("t1_ack_len", ack_count, 1);
        check("t1_err", err_count, 0);
        check("t1_busy_low", busy_low, 124);

        // Test 2: two simultaneous requests, pointer at 0
        pulse_reset();
        ReqData = 32'h00C2_00A0;
        Req     = 4'b0101;
        observe(400, 1'b1, 0);
        check("t2a_data", data_at_en, 32'hA0);
        check("t2a_ack_val", ack_val, 4'b0001);
        check("t2a_ack_cyc", ack_cyc, 104);
        check("t2a_busy_low", busy_low, 124);
        observe(400, 1'b1, 0);
        check("t2b_en_first", en_first, 1);
        check("t2b_en_len", en_count, 2);
        check("t2b_data", data_at_en, 32'hC2);
        check("t2b_ack_val", ack_val, 4'b0100);
        check("t2b_ack_cyc", ack_cyc, 104);

        // Test 3: all requesting, held high through Ack
        pulse_reset();
        ReqData = 32'h1312_1110;
        Req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            observe(400, 1'b0, 0);
            check($sformatf("t3_data%0d", k), data_at_en, 32'h10 + (k % 4));
            check($sformatf("t3_ack%0d", k), ack_val, 1 << (k % 4));
        end
        Req = 4'b0;

        // Test 4: transmitter never reports done -> timeout, then normal frame
        model_on = 1'b0;
        ReqData  = 32'h0000_3C00;
        Req      = 4'b0010;
        observe(400, 1'b1, 0);
        check("t4_data", data_at_en, 32'h3C);
        check("t4_ack_val", ack_val, 4'b0010);
        check("t4_ack_cyc", ack_cyc, 203);
        check("t4_err_at_ack", err_at_ack, 1);
        check("t4_err_len", err_count, 1);
        check("t4_busy_low", busy_low, 223);
        model_on = 1'b1;
        ReqData  = 32'h0077_0000;
        Req      = 4'b0100;
        observe(400, 1'b1, 0);
        check("t4n_data", data_at_en, 32'h77);
        check("t4n_ack_val", ack_val, 4'b0100);
        check("t4n_ack_cyc", ack_cyc, 104);
        check("t4n_err", err_count, 0);

        // Test 5: Req[3] withdrawn during WAIT
        ReqData = 32'hE100_0000;
        Req     = 4'b1000;
        observe(400, 1'b0, 10);
        check("t5_data", data_at_en, 32'hE1);
        check("t5_ack_val", ack_val, 4'b1000);
        check("t5_ack_cyc", ack_cyc, 104);
        check("t5_err", err_count, 0);

        // Test 6: reset in the middle of WAIT
        ReqData = 32'h0021_0000;
        Req     = 4'b0100;
        observe(400, 1'b1, 0);
        check("t6a_ack_val", ack_val, 4'b0100);
        ReqData = 32'h6B5A_0000;
        Req     = 4'b0100;
        repeat (50) @(negedge Clk);
        check("t6_wait_busy", Busy, 1);
        check("t6_wait_txen", TxEn, 0);
        check("t6_wait_data", TxData, 8'h5A);
        Rst_n = 1'b0;
        #1;
        check("t6_rst_busy", Busy, 0);
        check("t6_rst_txen", TxEn, 0);
        check("t6_rst_txdata", TxData, 0);
        check("t6_rst_ack", Ack, 0);
        check("t6_rst_err", Err, 0);
        Req = 4'b1100;
        repeat (2) @(negedge Clk);
        check("t6_rst_ack_hold", Ack, 0);
        Rst_n = 1'b1;
        observe(400, 1'b1, 0);
        check("t6b_en_first", en_first, 1);
        check("t6b_data", data_at_en, 32'h5A);
        check("t6b_ack_val", ack_val, 4'b0100);
        check("t6b_ack_cyc", ack_cyc, 104);
        observe(400, 1'b1, 0);
        check("t6c_data", data_at_en, 32'h6B);
        check("t6c_ack_val", ack_val, 4'b1000);
        check("t6c_ack_cyc", ack_cyc, 104);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmitter among `NREQ` byte-producing requesters. It selects one pending requester and drives `TxData`/`TxEn` into the transmitter. It then waits for the transmitter's `TxDone` (or a timeout), acknowledges the requester, and enforces an idle gap so the transmitter can return to idle before the next frame. It sits between client logic and the UART TX, in the same `Clk` domain as the baud generator.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 100000: `Clk` cycles allowed in WAIT before abort. Default exceeds one 8N1 frame at divisor 325 (52000 cycles).
- `GAP_CYCLES`, 400: minimum idle cycles after each frame. Must exceed one baud-tick period (325) so `TxDone` clears.
- `Clk`, in, 1: system clock.
- `Rst_n`, in, 1: reset, asynchronous, active-low.
- `Req`, in, NREQ: per-requester request level.
- `ReqData`, in, 8*NREQ: byte for requester i at `[8i+7:8i]`.
- `Ack`, out, NREQ: one-cycle completion pulse to the served requester.
- `Err`, out, 1: one-cycle pulse, coincident with `Ack`, when completion was by timeout.
- `Busy`, out, 1: high in every state except IDLE.
- `TxData`, out, 8: byte to the UART TX.
- `TxEn`, out, 1: start strobe to the UART TX, which detects its rising edge.
- `TxDone`, in, 1: UART TX done level, generated on the baud-tick clock. Treated as asynchronous.

## Operation
- **Reset values:** all outputs 0, state IDLE, round-robin pointer 0, counters 0, `TxDone` sync flops 0.
- **States:** IDLE -> LOAD -> WAIT -> GAP -> IDLE.
- **IDLE:** if any `Req` bit is high, grant the first set bit searching upward (with wrap) from the pointer.
  - Latch the grant index and `ReqData` of that index.
  - Go to LOAD.
- **LOAD:** exactly 2 cycles. `TxEn`=1; `TxData` = latched byte. Then go to WAIT.
- **WAIT:** `TxEn`=0; `TxData` held stable.
  - Cycle counter runs from 0.
  - On a rising edge of synchronized `TxDone`: pulse `Ack[g]`, go to GAP.
  - Else if counter reaches `TIMEOUT_CYCLES-1`: pulse `Ack[g]` and `Err`, go to GAP.
  - If both occur in the same cycle, `TxDone` wins and `Err`=0.
- **GAP:** `GAP_CYCLES` cycles, `TxData` still held. Then go to IDLE.
- **Pointer update:** pointer = g+1 mod NREQ, updated on leaving WAIT.
- **Requester rules:**
  - Hold `Req` and data stable until `Ack`.
  - Deasserting `Req` after grant does not cancel; the frame completes and `Ack` still pulses.
  - `Req` held high through `Ack` means a new request, eligible at the next IDLE.
  - `Req` changes outside IDLE are ignored.
- **`TxDone` synchronization:** two flops, then an edge register. A level already high on entry to WAIT does not count as an edge.
- **Reset mid-operation:** immediate return to reset values. No `Ack` is issued for the aborted frame.

## Timing
- `Req` high in IDLE at edge N -> LOAD from N+1: `TxEn`=1 and `TxData` valid for cycles N+1 and N+2. WAIT starts at N+3.
- `TxDone` rising before edge M -> `Ack` pulse in cycle M+3 (2 sync + 1 edge detect).
- Frame-to-frame minimum spacing: 2 + WAIT time + `GAP_CYCLES` + 1 cycles.
- Arbitration is combinational from `Req` and the pointer; the grant is registered. No combinational path from `Req` to any output.
- Counter widths: `$clog2(TIMEOUT_CYCLES)` and `$clog2(GAP_CYCLES)`. Both counters clear on every state entry.

## Structure
- Shared package `uart_ctrl_pkg`:
  - state enum (IDLE, LOAD, WAIT, GAP);
  - constants `UART_BAUD_DIV`=325, `UART_NBITS`=8, `LOAD_CYCLES`=2.
- Sub-module `rr_arbiter`, purely combinational:
  - inputs `Req[NREQ]` and pointer;
  - outputs one-hot grant and grant index.
- The top holds the FSM, counters, sync and data latch.

## Test plan
Bench uses `TIMEOUT_CYCLES`=200 and `GAP_CYCLES`=20. The UART TX model raises `TxDone` 100 cycles after the `TxEn` rise and drops it 30 cycles later.
1. `Req`=0010, byte 1 = 0x55 -> `TxData`=0x55, `TxEn` high exactly 2 cycles, `Ack`=0010 for 1 cycle with `Err`=0, `Busy` low after gap.
2. `Req`=0101 simultaneously, bytes 0xA0/0xC2 -> 0xA0 sent and acked first, then 0xC2. No overlap; gap ≥20 cycles.
3. `Req`=1111 held high, data 0x10+i -> send order 0x10, 0x11, 0x12, 0x13, 0x10.
4. Model never raises `TxDone` -> `Ack[g]` and `Err` pulse together 200 cycles into WAIT. Next request is served normally.
5. `Req[3]` dropped during WAIT -> frame still completes and `Ack`=1000 pulses.
6. `Rst_n` low mid-WAIT -> all outputs 0 within the reset. After release, a pending `Req`=0100 is granted before 1000 (pointer back to 0).
